// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the ysyx_24080006 core: AXI channel bundles split into
// read (AR/R) and write (AW/W/B) halves, plus the memory arbiter state enum.
package ysyx_24080006_pkg;

  localparam logic [3:0] RID_IFU_DEF = 4'h0;
  localparam logic [3:0] RID_LSU_DEF = 4'h1;

  // Master-to-slave half of an AXI read channel (AR plus R ready).
  typedef struct packed {
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
  } axi_r_m2s_t;

  // Slave-to-master half of an AXI read channel (AR ready plus R).
  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        rvalid;
  } axi_r_s2m_t;

  // Master-to-slave half of an AXI write channel (AW, W, B ready).
  typedef struct packed {
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi_w_m2s_t;

  // Slave-to-master half of an AXI write channel (AW/W ready plus B).
  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        bvalid;
  } axi_w_s2m_t;

  // Arbiter state doubles as the grant.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IFU = 2'd1,
    RD_LSU = 2'd2,
    WR_LSU = 2'd3
  } arb_fsm_e;

endpackage

// File: rtl/ysyx_24080006_axi_arbiter_pick.sv
// Winner select for the memory arbiter. Pure combinational policy block.
// Macro YSYX_24080006_ARB_RR_EN selects round-robin between IFU and LSU
// (LSU write beats LSU read); otherwise fixed priority LSU wr > LSU rd > IFU.
module ysyx_24080006_arb_pick
  import ysyx_24080006_pkg::*;
(
  input  logic     i_ifu_req,
  input  logic     i_lsu_rd_req,
  input  logic     i_lsu_wr_req,
  input  logic     i_last_lsu,
  output arb_fsm_e o_pick
);

`ifdef YSYX_24080006_ARB_RR_EN
  logic w_lsu_req;
  assign w_lsu_req = i_lsu_rd_req | i_lsu_wr_req;

  // On an IFU/LSU tie the master that was not granted last time wins.
  always_comb begin
    o_pick = IDLE;
    if (i_ifu_req && w_lsu_req) begin
      if (i_last_lsu)        o_pick = RD_IFU;
      else if (i_lsu_wr_req) o_pick = WR_LSU;
      else                   o_pick = RD_LSU;
    end else if (i_lsu_wr_req) begin
      o_pick = WR_LSU;
    end else if (i_lsu_rd_req) begin
      o_pick = RD_LSU;
    end else if (i_ifu_req) begin
      o_pick = RD_IFU;
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = i_last_lsu;

  // Fixed priority: stores first so the LSU never starves behind fetch.
  always_comb begin
    o_pick = IDLE;
    if (i_lsu_wr_req)      o_pick = WR_LSU;
    else if (i_lsu_rd_req) o_pick = RD_LSU;
    else if (i_ifu_req)    o_pick = RD_IFU;
  end
`endif

endmodule

// File: rtl/ysyx_24080006_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI arbiter with a
// single outstanding transaction. Policy macro: YSYX_24080006_ARB_RR_EN.
//
// Handshake rule: a channel transfers on a rising edge where valid and ready
// are both 1. The arbiter only forwards valid/ready for the granted channel;
// everything else sees 0, so losers stay pending and stray responses are
// dropped without being acknowledged.
module ysyx_24080006_axi_arbiter
  import ysyx_24080006_pkg::*;
#(
  parameter logic [3:0] RID_IFU = RID_IFU_DEF,
  parameter logic [3:0] RID_LSU = RID_LSU_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  axi_r_m2s_t ifu_r_m2s,
  output axi_r_s2m_t ifu_r_s2m,
  input  axi_r_m2s_t lsu_r_m2s,
  output axi_r_s2m_t lsu_r_s2m,
  input  axi_w_m2s_t lsu_w_m2s,
  output axi_w_s2m_t lsu_w_s2m,
  output axi_r_m2s_t mem_r_m2s,
  input  axi_r_s2m_t mem_r_s2m,
  output axi_w_m2s_t mem_w_m2s,
  input  axi_w_s2m_t mem_w_s2m,
  output arb_fsm_e   o_dbg_state
);

  arb_fsm_e r_state;
  arb_fsm_e w_pick;
  logic     w_last_lsu;

`ifdef YSYX_24080006_ARB_RR_EN
  logic r_last_lsu;

  // Remember who won the last IDLE-exit grant (0 = IFU, 1 = LSU).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_lsu <= 1'b0;
    end else if (r_state == IDLE && w_pick != IDLE) begin
      r_last_lsu <= (w_pick != RD_IFU);
    end
  end

  assign w_last_lsu = r_last_lsu;
`else
  assign w_last_lsu = 1'b0;
`endif

  ysyx_24080006_arb_pick u_pick (
    .i_ifu_req    (ifu_r_m2s.arvalid),
    .i_lsu_rd_req (lsu_r_m2s.arvalid),
    .i_lsu_wr_req (lsu_w_m2s.awvalid | lsu_w_m2s.wvalid),
    .i_last_lsu   (w_last_lsu),
    .o_pick       (w_pick)
  );

  // Grant FSM: IDLE picks a winner, a granted state holds until its final
  // response handshake, then always returns through IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    r_state <= w_pick;
        RD_IFU:  if (mem_r_s2m.rvalid && ifu_r_m2s.rready && mem_r_s2m.rlast) r_state <= IDLE;
        RD_LSU:  if (mem_r_s2m.rvalid && lsu_r_m2s.rready && mem_r_s2m.rlast) r_state <= IDLE;
        WR_LSU:  if (mem_w_s2m.bvalid && lsu_w_m2s.bready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Route the owner's channel to memory and memory back to the owner only.
  always_comb begin
    mem_r_m2s = '0;
    mem_w_m2s = '0;
    ifu_r_s2m = '0;
    lsu_r_s2m = '0;
    lsu_w_s2m = '0;
    case (r_state)
      RD_IFU: begin
        mem_r_m2s      = ifu_r_m2s;
        mem_r_m2s.arid = RID_IFU;
        ifu_r_s2m      = mem_r_s2m;
      end
      RD_LSU: begin
        mem_r_m2s      = lsu_r_m2s;
        mem_r_m2s.arid = RID_LSU;
        lsu_r_s2m      = mem_r_s2m;
      end
      WR_LSU: begin
        mem_w_m2s      = lsu_w_m2s;
        mem_w_m2s.awid = RID_LSU;
        lsu_w_s2m      = mem_w_s2m;
      end
      default: ;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule
